// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader FSM state encoding, the default frame sync byte and
// the width of the frame length field.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_WIDTH         = 16;

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input, imem write port and processor-control bundle of the loader.
// master: the loader (consumes bytes, drives imem write and status).
// slave:  the surroundings (byte source, imem, processor control).
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_wren;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_data;
  logic                  proc_reset;
  logic                  load_done;
  logic                  load_error;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_wren, imem_address, imem_data,
    output proc_reset, load_done, load_error
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_wren, imem_address, imem_data,
    input  proc_reset, load_done, load_error
  );

endinterface

// File: rtl/imem_program_loader_word_assembler.sv
// Packs accepted data bytes MSB-first into 32-bit words and keeps the running XOR.
// word_ready is combinational: high in the cycle the 4th byte of a word is accepted.
// No backpressure of its own; the caller only enables it on accepted bytes.
module loader_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_xor_en,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word,
  output logic [7:0]  o_xor
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  logic [7:0]  r_xor;

  // The current byte completes the word, so it is appended without being stored.
  assign o_word       = {r_shift, i_byte};
  assign o_word_ready = i_shift_en && (r_cnt == 2'd3);
  assign o_xor        = r_xor;

  // Shift register, byte-in-word counter and checksum accumulator.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_xor   <= '0;
    end else begin
      if (i_xor_en) begin
        r_xor <= r_xor ^ i_byte;
      end
      if (i_shift_en) begin
        r_shift <= {r_shift[15:0], i_byte};
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a framed byte stream (SYNC, LEN_HI, LEN_LO, LEN words MSB-first, CHK) into imem.
// Write latency: imem_wren one cycle after the handshake of a word's 4th byte.
// Accepts one byte per cycle at full rate; in_ready low only in reset and the cycle after it.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  imem_program_loader_if.master bus
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  state_e                r_state;
  state_e                w_next_state;
  logic                  r_in_ready;
  logic [7:0]            r_len_hi;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_word_cnt;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic                  r_proc_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_sync;
  logic                  w_len_err;
  logic                  w_chk_ok;
  logic                  w_chk_bad;
  logic                  w_xor_en;
  logic                  w_shift_en;
  logic                  w_word_ready;
  logic [31:0]           w_word;
  logic [7:0]            w_xor;

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_len      = {r_len_hi, bus.in_data};
  // Datapath enables depend only on state and handshake, never on word_ready.
  assign w_xor_en   = w_accept && (r_state == LEN_HI || r_state == LEN_LO || r_state == DATA);
  assign w_shift_en = w_accept && (r_state == DATA);

  loader_word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_sync),
    .i_xor_en     (w_xor_en),
    .i_shift_en   (w_shift_en),
    .i_byte       (bus.in_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word),
    .o_xor        (w_xor)
  );

  // Next-state and per-byte event decode; nothing moves without an accepted byte.
  always_comb begin
    w_next_state = r_state;
    w_sync       = 1'b0;
    w_len_err    = 1'b0;
    w_chk_ok     = 1'b0;
    w_chk_bad    = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (bus.in_data == SYNC_BYTE) begin
            w_sync       = 1'b1;
            w_next_state = LEN_HI;
          end
        end
        LEN_HI: w_next_state = LEN_LO;
        LEN_LO: begin
          if (w_len == '0) begin
            w_next_state = CHECK;
          end else if (32'(w_len) > MAX_WORDS) begin
            w_len_err    = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = DATA;
          end
        end
        DATA: begin
          if (w_word_ready && (r_word_cnt == r_len - 1'b1)) begin
            w_next_state = CHECK;
          end
        end
        CHECK: begin
          w_next_state = IDLE;
          if (bus.in_data == w_xor) begin
            w_chk_ok = 1'b1;
          end else begin
            w_chk_bad = 1'b1;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ready flag, captured length and index of the next word to write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_ready <= 1'b0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
    end else begin
      r_in_ready <= 1'b1;
      if (w_accept && r_state == LEN_HI) begin
        r_len_hi <= bus.in_data;
      end
      if (w_accept && r_state == LEN_LO) begin
        r_len <= w_len;
      end
      if (w_sync) begin
        r_word_cnt <= '0;
      end else if (w_word_ready) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  // imem write port; reset drops any write that was due on the next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wren <= w_word_ready;
      if (w_word_ready) begin
        r_addr <= r_word_cnt[ADDR_WIDTH-1:0];
        r_data <= w_word;
      end
    end
  end

  // Processor hold and sticky load status; a new sync re-arms everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_proc_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else if (w_sync) begin
      r_proc_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else if (w_len_err || w_chk_bad) begin
      r_error <= 1'b1;
    end else if (w_chk_ok) begin
      r_done       <= 1'b1;
      r_proc_reset <= 1'b0;
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.imem_wren    = r_wren;
  assign bus.imem_address = r_addr;
  assign bus.imem_data    = r_data;
  assign bus.proc_reset   = r_proc_reset;
  assign bus.load_done    = r_done;
  assign bus.load_error   = r_error;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: inputs driven and outputs checked on the falling edge.
// Expected values are hand-computed from the frame format (checksum = XOR of LEN and data bytes).
module tb_imem_program_loader;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   wr_count;

  imem_program_loader_if #(.ADDR_WIDTH(12)) bus ();

  imem_program_loader #(
    .ADDR_WIDTH (12),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts write strobes; wren is sampled at the edge, before it can change.
  always @(posedge clock) begin
    if (bus.imem_wren === 1'b1) wr_count++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One byte per cycle; returns on the following falling edge so calls chain without bubbles.
  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic stall_cycle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hA5;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},   32'(bus.in_ready),     32'd0);
    check({tag, ".wren"},       32'(bus.imem_wren),    32'd0);
    check({tag, ".addr"},       32'(bus.imem_address), 32'd0);
    check({tag, ".data"},       bus.imem_data,         32'd0);
    check({tag, ".proc_reset"}, 32'(bus.proc_reset),   32'd1);
    check({tag, ".done"},       32'(bus.load_done),    32'd0);
    check({tag, ".error"},      32'(bus.load_error),   32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    wr_count     = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);

    // Reset values, then the single not-ready cycle after release.
    check_reset_values("rst");
    reset = 1'b0;
    check("rel.in_ready_first", 32'(bus.in_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("rel.in_ready", 32'(bus.in_ready), 32'd1);
    repeat (5) stall_cycle();
    check("idle.proc_reset", 32'(bus.proc_reset), 32'd1);
    check("idle.done",       32'(bus.load_done),  32'd0);
    check("idle.error",      32'(bus.load_error), 32'd0);
    check("idle.wr_count",   32'(wr_count),       32'd0);

    // Good frame: XOR 00^02^00^00^00^01^12^34^56^78 = 0B.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("w0.wren", 32'(bus.imem_wren),    32'd1);
    check("w0.addr", 32'(bus.imem_address), 32'd0);
    check("w0.data", bus.imem_data,         32'h0000_0001);
    send_byte(8'h12);
    check("w0.one_cycle", 32'(bus.imem_wren), 32'd0);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check("w1.wren", 32'(bus.imem_wren),    32'd1);
    check("w1.addr", 32'(bus.imem_address), 32'd1);
    check("w1.data", bus.imem_data,         32'h1234_5678);
    check("w1.proc_reset_held", 32'(bus.proc_reset), 32'd1);
    send_byte(8'h0B);
    check("good.done",       32'(bus.load_done),  32'd1);
    check("good.proc_reset", 32'(bus.proc_reset), 32'd0);
    check("good.error",      32'(bus.load_error), 32'd0);
    check("good.wr_count",   32'(wr_count),       32'd2);

    // Same frame with a wrong checksum; the sync re-asserts the processor hold.
    send_byte(8'hA5);
    check("rearm.proc_reset", 32'(bus.proc_reset), 32'd1);
    check("rearm.done",       32'(bus.load_done),  32'd0);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h0C);
    check("bad.error",      32'(bus.load_error), 32'd1);
    check("bad.done",       32'(bus.load_done),  32'd0);
    check("bad.proc_reset", 32'(bus.proc_reset), 32'd1);
    check("bad.wr_count",   32'(wr_count),       32'd4);

    // Junk in IDLE is discarded, then an empty frame (LEN=0, CHK=00).
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk.error_sticky", 32'(bus.load_error), 32'd1);
    send_byte(8'hA5);
    check("empty.error_clr", 32'(bus.load_error), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("empty.done",       32'(bus.load_done),  32'd1);
    check("empty.proc_reset", 32'(bus.proc_reset), 32'd0);
    check("empty.wr_count",   32'(wr_count),       32'd4);

    // LEN=4097 exceeds 2**12 words: error right after LEN_LO, back in IDLE.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
    check("len.error",      32'(bus.load_error), 32'd1);
    check("len.proc_reset", 32'(bus.proc_reset), 32'd1);
    check("len.done",       32'(bus.load_done),  32'd0);
    // A stray byte then an empty frame only completes if the loader sat in IDLE.
    send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("len.idle_done", 32'(bus.load_done), 32'd1);
    check("len.wr_count",  32'(wr_count),      32'd4);

    // Stalls every other cycle, then reset after two data bytes.
    send_byte(8'hA5);
    stall_cycle();
    check("stall.proc_reset", 32'(bus.proc_reset), 32'd1);
    check("stall.done",       32'(bus.load_done),  32'd0);
    send_byte(8'h00);
    stall_cycle();
    send_byte(8'h01);
    stall_cycle();
    send_byte(8'hDE);
    stall_cycle();
    send_byte(8'hAD);
    stall_cycle();
    check("stall.no_wren", 32'(bus.imem_wren), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_values("mid");
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);

    // Full frame after the abort: XOR 00^01^CA^FE^BA^BE = 31, word lands at address 0.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    check("post.wren", 32'(bus.imem_wren),    32'd1);
    check("post.addr", 32'(bus.imem_address), 32'd0);
    check("post.data", bus.imem_data,         32'hCAFE_BABE);
    send_byte(8'h31);
    check("post.done",       32'(bus.load_done),  32'd1);
    check("post.proc_reset", 32'(bus.proc_reset), 32'd0);
    check("post.wr_count",   32'(wr_count),       32'd5);

    // Reset arriving with a word's 4th byte suppresses the pending write.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    bus.in_data  = 8'h44;
    bus.in_valid = 1'b1;
    reset        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("sup.wren",       32'(bus.imem_wren),  32'd0);
    check("sup.proc_reset", 32'(bus.proc_reset), 32'd1);
    check("sup.in_ready",   32'(bus.in_ready),   32'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("sup.wr_count", 32'(wr_count),         32'd5);
    check("sup.addr",     32'(bus.imem_address), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
